// File: rtl/serial_bit_subtractor_if.sv
// serial_bit_subtractor_if
//   Request/response bundle for serial_bit_subtractor.
//   master : requester (drives start, a, b, bw_in; observes results)
//   slave  : subtractor (consumes the request; drives diff, bw_out, busy, done)
//   Ports  : start, a[WIDTH], b[WIDTH], bw_in  -> subtractor
//            diff[WIDTH], bw_out, busy, done    <- subtractor
//            ovf <- subtractor, only when SERIAL_SUB_OVF_EN is defined
interface serial_bit_subtractor_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bw_in;
    logic [WIDTH-1:0] diff;
    logic             bw_out;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bw_in,
                    input  diff, bw_out, busy, done, ovf);
    modport slave  (input  start, a, b, bw_in,
                    output diff, bw_out, busy, done, ovf);
`else
    modport master (output start, a, b, bw_in,
                    input  diff, bw_out, busy, done);
    modport slave  (input  start, a, b, bw_in,
                    output diff, bw_out, busy, done);
`endif
endinterface

// File: rtl/serial_bit_subtractor.sv
// serial_bit_subtractor
//   Bit-serial subtractor: diff = a - b - bw_in (mod 2^WIDTH), one bit per
//   clock, LSB first. Result appears WIDTH cycles after start is accepted.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-low reset
//     bus  - serial_bit_subtractor_if.slave (start/a/b/bw_in in,
//            diff/bw_out/busy/done out, ovf out when enabled)
//   Configuration:
//     SERIAL_SUB_OVF_EN - when defined, adds registered two's-complement
//                         overflow flag ovf, updated together with diff.
module serial_bit_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_bit_subtractor_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [WIDTH-1:0] diff_q;
    logic             bw, bw_out_q;
    logic [CW-1:0]    cnt;
    logic             d, bw_nxt, last;
    logic             busy_c, done_c;

    // Per-bit full subtractor on the current LSBs.
    always_comb begin
        d      = a_sh[0] ^ b_sh[0] ^ bw;
        bw_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bw);
        last   = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy_c = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = bus.start ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are shifted out of a_sh/b_sh, so keep copies.
    logic a_msb, b_msb, ovf_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            bw       <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            bw_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sh <= bus.a;
                        b_sh <= bus.b;
                        bw   <= bus.bw_in;
                        cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= bus.a[WIDTH-1];
                        b_msb <= bus.b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= {d, r_sh[WIDTH-1:1]};
                    bw   <= bw_nxt;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        // Final bit goes straight to the output register.
                        diff_q   <= {d, r_sh[WIDTH-1:1]};
                        bw_out_q <= bw_nxt;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q    <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.diff   = diff_q;
    assign bus.bw_out = bw_out_q;
    assign bus.busy   = busy_c;
    assign bus.done   = done_c;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_bit_subtractor.sv
// tb_serial_bit_subtractor
//   Scoreboard bench: the driver pushes the arithmetic expectation for each
//   accepted request; a negedge monitor pops and compares on every done.
module tb_serial_bit_subtractor;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_bit_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_bit_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bw_out;
        logic             ovf;
        int               done_cyc;
    } exp_t;

    exp_t             q[$];
    int               checks = 0;
    int               fails  = 0;
    int               cyc    = 0;
    logic [WIDTH-1:0] held_diff = '0;
    logic             held_bw   = 1'b0;
    logic             held_ovf  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bw, input int k);
        exp_t e;
        int   ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        r  = ia - ib - int'(bw);
        if (r < 0) r = r + (1 << WIDTH);
        e.diff     = r[WIDTH-1:0];
        e.bw_out   = (ia < ib + int'(bw));
        e.ovf      = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ e.diff[WIDTH-1]);
        e.done_cyc = k + WIDTH;
        return e;
    endfunction

    // Called at a negedge with the DUT in IDLE or DONE; returns just after edge k.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bw);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bw_in = bw;
        @(posedge clk);
        #1;
        q.push_back(model(a, b, bw, cyc));
        bus.start = 1'b0;
        bus.a     = WIDTH'($urandom);
        bus.b     = WIDTH'($urandom);
        bus.bw_in = 1'(($urandom));
    endtask

    // Waits (bounded) for the done negedge; optionally fires an ignored start mid-operation.
    task automatic wait_done(input bit garbage);
        int unsigned busy_n = 0;
        bit          seen   = 1'b0;
        for (int i = 0; i < int'(WIDTH) + 4 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) busy_n++;
                if (garbage && i == 2) begin
                    bus.start = 1'b1;
                    bus.a     = '1;
                    bus.b     = '0;
                    bus.bw_in = 1'b0;
                end else if (garbage && i == 3) begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
        chk("busy_cycles", 64'(busy_n), 64'(WIDTH));
    endtask

    // Monitor: output holding during SHIFT, and result/latency on done.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (bus.busy) begin
                chk("hold_diff", 64'(bus.diff), 64'(held_diff));
                chk("hold_bw_out", 64'(bus.bw_out), 64'(held_bw));
`ifdef SERIAL_SUB_OVF_EN
                chk("hold_ovf", 64'(bus.ovf), 64'(held_ovf));
`endif
            end
            if (bus.done) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no pending request (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    chk("diff", 64'(bus.diff), 64'(e.diff));
                    chk("bw_out", 64'(bus.bw_out), 64'(e.bw_out));
                    chk("latency", 64'(cyc), 64'(e.done_cyc));
                    chk("busy_in_done", 64'(bus.busy), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
                    chk("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
                    held_diff = e.diff;
                    held_bw   = e.bw_out;
                    held_ovf  = e.ovf;
                end
            end
        end
    end

    typedef struct { logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; logic bw; } vec_t;
    vec_t dir[] = '{
        '{8'd10,  8'd3,   1'b0},
        '{8'd3,   8'd10,  1'b0},
        '{8'd5,   8'd5,   1'b1},
        '{8'd0,   8'd1,   1'b0},
        '{8'h80,  8'h01,  1'b0},
        '{8'h05,  8'h03,  1'b0},
        '{8'hFF,  8'hFF,  1'b1},
        '{8'h7F,  8'hFF,  1'b0}
    };

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bw_in = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_diff", 64'(bus.diff), 64'd0);
        chk("rst_bw_out", 64'(bus.bw_out), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
        rst = 1'b1;
        @(negedge clk);

        // Directed vectors, one per operation with idle gaps
        foreach (dir[i]) begin
            launch(dir[i].a, dir[i].b, dir[i].bw);
            wait_done(1'b0);
            @(negedge clk);
        end

        // Ignored start mid-operation, then back-to-back start in the DONE cycle
        launch(8'd9, 8'd4, 1'b0);
        wait_done(1'b1);
        launch(8'h33, 8'h44, 1'b1);
        wait_done(1'b0);
        @(negedge clk);

        // Reset in the middle of an operation
        launch(8'h55, 8'h22, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_diff", 64'(bus.diff), 64'd0);
        chk("abort_bw_out", 64'(bus.bw_out), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        q.delete();
        held_diff = '0;
        held_bw   = 1'b0;
        held_ovf  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < int'(WIDTH) + 2; i++) begin
            @(negedge clk);
            chk("post_abort_done", 64'(bus.done), 64'd0);
        end
        launch(8'h20, 8'h01, 1'b0);
        wait_done(1'b0);

        // Randomized operations, mixing back-to-back and gapped requests
        for (int n = 0; n < 60; n++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            if ($urandom_range(0, 7) == 0) ra = '0;
            if ($urandom_range(0, 7) == 0) rb = '1;
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            launch(ra, rb, 1'($urandom_range(0, 1)));
            wait_done(1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
